// File: rtl/scmp_useq_pkg.sv
// scmp_useq_pkg: shared types and default widths for the SC/MP microcode
// sequencer and the microcode ROM field decode that feeds it.
package scmp_useq_pkg;

  localparam int UPC_W_DEF   = 8;
  localparam int COND_W_DEF  = 4;
  localparam int DISP_W_DEF  = 8;
  localparam int STACK_D_DEF = 2;

  // Sequencing op carried in every microword.
  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JREL     = 3'd1,
    SEQ_START    = 3'd2,
    SEQ_DISPATCH = 3'd3,
    SEQ_CALL     = 3'd4,
    SEQ_RET      = 3'd5,
    SEQ_JABS     = 3'd6,
    SEQ_RSVD     = 3'd7
  } seq_op_t;

  // Sequencing fields of one microword, as produced by the ROM field decode.
  typedef struct packed {
    seq_op_t                op;
    logic [DISP_W_DEF-1:0]  disp;
    logic [COND_W_DEF-1:0]  cond_mask;
    logic [COND_W_DEF-1:0]  cond_xor;
    logic                   wait_rdy;
  } useq_fields_t;

endpackage

// File: rtl/scmp_useq_stack.sv
// scmp_useq_stack: small LIFO of return addresses. Entry 0 is the top of
// stack; a push shifts every entry one slot deeper, so on a full push the
// deepest (oldest) entry falls off the end. Slots at or below the current
// count always hold zero.
module scmp_useq_stack #(
  parameter int  W     = 8,
  parameter int  D     = 2,
  localparam int CNT_W = $clog2(D + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(D);

  logic [W-1:0]     mem_q [D];
  logic [W-1:0]     mem_d [D];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign top   = mem_q[0];
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // Next entries and count: push shifts down (saturating count), pop shifts up.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push) begin
      for (int i = D - 1; i > 0; i--) begin
        mem_d[i] = mem_q[i-1];
      end
      mem_d[0] = push_data;
      if (!full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      for (int i = 0; i < D - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[D-1] = '0;
      cnt_d      = cnt_q - CNT_W'(1);
    end
  end

  // Entry and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        mem_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scmp_useq.sv
// scmp_useq: SC/MP microcode sequencer. Produces the registered microcode
// address upc from the current microword's sequencing fields, condition
// inputs, opcode dispatch address and the bus wait handshake.
// Build option SCMP_USEQ_STACK_EN: when defined, a STACK_D-deep call stack
// with sticky overflow/underflow flags; otherwise a single return register
// and both flags tied low.
// stk_cnt is a debug view of the call stack fill level (0 without the stack).
module scmp_useq
  import scmp_useq_pkg::*;
#(
  parameter int  UPC_W   = UPC_W_DEF,
  parameter int  COND_W  = COND_W_DEF,
  parameter int  DISP_W  = DISP_W_DEF,
  parameter int  STACK_D = STACK_D_DEF,
  localparam int CNT_W   = $clog2(STACK_D + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COND_W-1:0] cond_in,
  input  logic [UPC_W-1:0]  dispatch_addr,
  input  logic              bus_rdy,
  input  logic [2:0]        seq_op,
  input  logic [DISP_W-1:0] seq_disp,
  input  logic [COND_W-1:0] seq_cond_mask,
  input  logic [COND_W-1:0] seq_cond_xor,
  input  logic              seq_wait,
  output logic [UPC_W-1:0]  upc,
  output logic              stall,
  output logic              stk_ovf,
  output logic              stk_unf,
  output logic [CNT_W-1:0]  stk_cnt
);

  logic [UPC_W-1:0] upc_q;
  logic [UPC_W-1:0] upc_d;
  logic [UPC_W-1:0] upc_inc;
  logic [UPC_W-1:0] upc_rel;
  logic [UPC_W-1:0] ret_addr;
  logic             ret_empty;
  logic             cond;
  logic             call_fire;
  seq_op_t          op;

  assign op  = seq_op_t'(seq_op);
  assign upc = upc_q;

  // Wait handshake: a microword with seq_wait=1 is held (stall=1) on every
  // edge where bus_rdy=0 and advances on the first edge with bus_rdy=1.
  // bus_rdy is a don't-care whenever seq_wait=0. A stalled cycle changes
  // no state at all (no upc change, no push or pop, no flag update).
  assign stall = seq_wait & ~bus_rdy;

  // An empty mask gives cond=0; cond_xor flips the polarity per source.
  assign cond = |((cond_in ^ seq_cond_xor) & seq_cond_mask);

  // Sign-extending seq_disp and then reducing modulo 2^UPC_W keeps only
  // its low UPC_W bits, so the relative target is a plain truncated add.
  assign upc_inc = upc_q + UPC_W'(1);
  assign upc_rel = upc_q + seq_disp[UPC_W-1:0];

`ifdef SCMP_USEQ_STACK_EN
  logic             ret_fire;
  logic             stk_full;
  logic             stk_empty;
  logic [UPC_W-1:0] stk_top;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;
`else
  logic [UPC_W-1:0] ret_q;
  logic [UPC_W-1:0] ret_d;
`endif

  // Next microaddress: stall holds, a true condition skips, else seq_op.
  always_comb begin
    upc_d     = upc_q;
    call_fire = 1'b0;
`ifdef SCMP_USEQ_STACK_EN
    ret_fire  = 1'b0;
`endif
    if (stall) begin
      upc_d = upc_q;
    end else if (cond) begin
      upc_d = upc_inc;
    end else begin
      case (op)
        SEQ_NEXT:     upc_d = upc_inc;
        SEQ_JREL:     upc_d = upc_rel;
        SEQ_DISPATCH: upc_d = dispatch_addr;
        SEQ_CALL: begin
          call_fire = 1'b1;
          upc_d     = upc_rel;
        end
        SEQ_RET: begin
`ifdef SCMP_USEQ_STACK_EN
          ret_fire = 1'b1;
`endif
          upc_d    = ret_empty ? '0 : ret_addr;
        end
        SEQ_JABS:     upc_d = seq_disp[UPC_W-1:0];
        // START and the reserved encoding both restart at microaddress 0.
        default:      upc_d = '0;
      endcase
    end
  end

  // Microaddress register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upc_q <= '0;
    end else begin
      upc_q <= upc_d;
    end
  end

`ifdef SCMP_USEQ_STACK_EN
  scmp_useq_stack #(
    .W (UPC_W),
    .D (STACK_D)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (call_fire),
    .pop       (ret_fire),
    .push_data (upc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .count     (stk_cnt)
  );

  assign ret_addr  = stk_top;
  assign ret_empty = stk_empty;

  // Sticky flags: only rst clears them.
  always_comb begin
    ovf_d = ovf_q | (call_fire & stk_full);
    unf_d = unf_q | (ret_fire & stk_empty);
  end

  // Flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
`else
  // Single return register: every CALL overwrites it, RET always uses it.
  always_comb begin
    ret_d = call_fire ? upc_inc : ret_q;
  end

  // Return register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_q <= '0;
    end else begin
      ret_q <= ret_d;
    end
  end

  assign ret_addr  = ret_q;
  assign ret_empty = 1'b0;
  assign stk_ovf   = 1'b0;
  assign stk_unf   = 1'b0;
  assign stk_cnt   = '0;
`endif

endmodule

// File: tb/tb_scmp_useq.sv
// tb_scmp_useq: directed and randomized checks of scmp_useq against a
// queue-based behavioural model of the sequencing rules.
module tb_scmp_useq;
  import scmp_useq_pkg::*;

  localparam int UPC_W   = 8;
  localparam int COND_W  = 4;
  localparam int DISP_W  = 8;
  localparam int STACK_D = 2;
  localparam int CNT_W   = $clog2(STACK_D + 1);
  localparam int UMASK   = (1 << UPC_W) - 1;

  logic              clk;
  logic              rst;
  logic [COND_W-1:0] cond_in;
  logic [UPC_W-1:0]  dispatch_addr;
  logic              bus_rdy;
  logic [2:0]        seq_op;
  logic [DISP_W-1:0] seq_disp;
  logic [COND_W-1:0] seq_cond_mask;
  logic [COND_W-1:0] seq_cond_xor;
  logic              seq_wait;
  logic [UPC_W-1:0]  upc;
  logic              stall;
  logic              stk_ovf;
  logic              stk_unf;
  logic [CNT_W-1:0]  stk_cnt;

  scmp_useq #(
    .UPC_W   (UPC_W),
    .COND_W  (COND_W),
    .DISP_W  (DISP_W),
    .STACK_D (STACK_D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cond_in       (cond_in),
    .dispatch_addr (dispatch_addr),
    .bus_rdy       (bus_rdy),
    .seq_op        (seq_op),
    .seq_disp      (seq_disp),
    .seq_cond_mask (seq_cond_mask),
    .seq_cond_xor  (seq_cond_xor),
    .seq_wait      (seq_wait),
    .upc           (upc),
    .stall         (stall),
    .stk_ovf       (stk_ovf),
    .stk_unf       (stk_unf),
    .stk_cnt       (stk_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_upc;
  int m_stk[$];   // back = most recent return address
  int m_ret;
  bit m_ovf;
  bit m_unf;

  function automatic void model_reset();
    m_upc = 0;
    m_stk.delete();
    m_ret = 0;
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic int sext_disp(input int d);
    return (d >= (1 << (DISP_W - 1))) ? d - (1 << DISP_W) : d;
  endfunction

  function automatic void model_step(input int op, input int disp, input int mask,
                                     input int xr, input int cin, input int wt,
                                     input int rdy, input int disp_addr);
    int rel;
    bit c;
    c   = (((cin ^ xr) & mask) != 0);
    rel = (m_upc + sext_disp(disp)) & UMASK;
    if (wt != 0 && rdy == 0) return;
    if (c) begin
      m_upc = (m_upc + 1) & UMASK;
      return;
    end
    case (op)
      0: m_upc = (m_upc + 1) & UMASK;
      1: m_upc = rel;
      3: m_upc = disp_addr;
      4: begin
`ifdef SCMP_USEQ_STACK_EN
        if (m_stk.size() == STACK_D) begin
          void'(m_stk.pop_front());
          m_ovf = 1;
        end
        m_stk.push_back((m_upc + 1) & UMASK);
`else
        m_ret = (m_upc + 1) & UMASK;
`endif
        m_upc = rel;
      end
      5: begin
`ifdef SCMP_USEQ_STACK_EN
        if (m_stk.size() == 0) begin
          m_upc = 0;
          m_unf = 1;
        end else begin
          m_upc = m_stk.pop_back();
        end
`else
        m_upc = m_ret;
`endif
      end
      6: m_upc = disp & UMASK;
      default: m_upc = 0;
    endcase
  endfunction

  function automatic int model_cnt();
`ifdef SCMP_USEQ_STACK_EN
    return m_stk.size();
`else
    return 0;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  logic [UPC_W-1:0] exp_q[$];
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One microword cycle: drive on the falling edge, check stall, then check
  // the registered state just after the rising edge.
  task automatic step(input int op, input int disp, input int mask, input int xr,
                      input int cin, input int wt, input int rdy, input int disp_addr);
    @(negedge clk);
    seq_op        = 3'(op);
    seq_disp      = DISP_W'(disp);
    seq_cond_mask = COND_W'(mask);
    seq_cond_xor  = COND_W'(xr);
    cond_in       = COND_W'(cin);
    seq_wait      = (wt != 0);
    bus_rdy       = (rdy != 0);
    dispatch_addr = UPC_W'(disp_addr);
    #1;
    check("stall", {31'd0, stall}, {31'd0, (wt != 0 && rdy == 0)});
    model_step(op, disp, mask, xr, cin, wt, rdy, disp_addr);
    exp_q.push_back(UPC_W'(m_upc));
    @(posedge clk);
    #1;
    check("upc", 32'(upc), 32'(exp_q.pop_front()));
    check("stk_ovf", {31'd0, stk_ovf}, {31'd0, m_ovf});
    check("stk_unf", {31'd0, stk_unf}, {31'd0, m_unf});
    check("stk_cnt", 32'(stk_cnt), 32'(model_cnt()));
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jabs(input int a);
    step(6, a, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset between clock edges; state must clear without an edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_upc", 32'(upc), 32'd0);
    check("rst_ovf", {31'd0, stk_ovf}, 32'd0);
    check("rst_unf", {31'd0, stk_unf}, 32'd0);
    check("rst_cnt", 32'(stk_cnt), 32'd0);
    seq_wait = 1'b1;
    bus_rdy  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    rst = 1'b1;
    cond_in = '0; dispatch_addr = '0; bus_rdy = 1'b0; seq_op = '0;
    seq_disp = '0; seq_cond_mask = '0; seq_cond_xor = '0; seq_wait = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_upc", 32'(upc), 32'd0);
    check("rst_ovf", {31'd0, stk_ovf}, 32'd0);
    check("rst_unf", {31'd0, stk_unf}, 32'd0);
    rst = 1'b0;

    // Sequential fetch and negative relative jump.
    nop(3);
    step(1, 'hFE, 0, 0, 0, 0, 0, 0);

    // Condition skip versus taken JABS.
    nop(4);
    step(6, 'h40, 1, 0, 1, 0, 0, 0);
    step(6, 'h40, 1, 0, 0, 0, 0, 0);

    // Wait handshake: three stalled cycles then release.
    jabs(2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);

    // Nested calls beyond the stack depth, then unwind past empty.
    jabs('h10);
    for (int i = 0; i < 3; i++) step(4, 'h10, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(5, 0, 0, 0, 0, 0, 0, 0);

    // CALL immediately followed by RET; suppressed CALLs push nothing.
    step(4, 'h08, 0, 0, 0, 0, 0, 0);
    step(5, 0, 0, 0, 0, 0, 0, 0);
    step(4, 'h08, 2, 2, 0, 0, 0, 0);
    step(4, 'h08, 0, 0, 0, 1, 0, 0);

    // Dispatch, address wrap, START and reserved op.
    step(3, 0, 0, 0, 0, 0, 0, 'h80);
    jabs('hFF);
    nop(1);
    step(2, 0, 0, 0, 0, 0, 0, 0);
    jabs('h33);
    step(7, 0, 0, 0, 0, 0, 0, 0);

    // Reset while waiting with one return address on the stack.
    async_reset();
    jabs('h20);
    step(4, 'h10, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    async_reset();
    step(5, 0, 0, 0, 0, 0, 0, 0);

    // Randomized microword streams.
    async_reset();
    for (int i = 0; i < 400; i++) begin
      int op, mask;
      op   = $urandom_range(0, 7);
      mask = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
      step(op, $urandom_range(0, 255), mask, $urandom_range(0, 15),
           $urandom_range(0, 15), ($urandom_range(0, 4) == 0) ? 1 : 0,
           $urandom_range(0, 1), $urandom_range(0, 255));
      if (i == 200) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
